// File: rtl/gate_check_pkg.sv
// Shared types and truth-table constants for checking the team's 3-input dataflow gates.
package gate_check_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_e;

    localparam int unsigned NUM_VECTORS = 8;

    // Bit i holds F for input index {A,B,C} == i.
    localparam logic [7:0] GATE2_POS_TT = 8'h54;

endpackage

// File: rtl/truth_table_checker.sv
// Sweeps all eight {A,B,C} vectors into a gate, samples F after a settle hold
// and compares each sample against an expected truth table.
module truth_table_checker
    import gate_check_pkg::*;
#(
    parameter logic [7:0]  EXPECTED      = GATE2_POS_TT,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_mask,
    output logic [7:0] captured
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LastIdx    = 3'(NUM_VECTORS - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic [7:0] fail_q, fail_d;
    logic [7:0] cap_q, cap_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            err_q   <= 4'd0;
            fail_q  <= 8'h00;
            cap_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            cap_q   <= cap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        cap_d   = cap_q;

        unique case (state_q)
            StIdle, StDone: begin
                // A start from DONE restarts exactly like one from IDLE.
                if (start) begin
                    state_d = StDrive;
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    err_d   = 4'd0;
                    fail_d  = 8'h00;
                    cap_d   = 8'h00;
                end
            end
            StDrive: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SettleLast) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                cap_d[idx_q] = f;
                if (f != EXPECTED[idx_q]) begin
                    fail_d[idx_q] = 1'b1;
                    err_d         = err_q + 4'd1;
                end
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = 4'd0;
                    state_d = StDrive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q == StDrive) || (state_q == StSample);
    assign done        = (state_q == StDone);
    assign pass        = done && (err_q == 4'd0);
    assign {a, b, c}   = busy ? idx_q : 3'b000;
    assign err_count   = err_q;
    assign fail_mask   = fail_q;
    assign captured    = cap_q;

endmodule
